// File: rtl/r8mbe_pkg.sv
// Shared types and helpers for the radix-8 Modified Booth multipliers.
//   state_t      : control states of the iterative multiplier
//   digit_sel_t  : one-hot magnitude select plus sign for one Booth digit
//   r8_digits()  : number of radix-8 digits for an n-bit operand
package r8mbe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
    logic three;
    logic four;
  } digit_sel_t;

  // ceil((n+1)/3): the extra bit keeps the top digit non-negative for unsigned operands
  function automatic int unsigned r8_digits(input int unsigned n);
    return (n + 3) / 3;
  endfunction

endpackage

// File: rtl/r8mbe_digit_enc.sv
// Radix-8 Booth recoder: 4-bit window {b[3i+2], b[3i+1], b[3i], b[3i-1]}
// to sign + one-hot magnitude {1,2,3,4}; all-zero magnitude means digit 0.
//   win_i  : input  4-bit overlapping window of the multiplier
//   sel_c  : output combinational digit select
module r8mbe_digit_enc
  import r8mbe_pkg::*;
(
  input  logic [3:0] win_i,
  output digit_sel_t sel_c
);

  always_comb begin
    sel_c     = '0;
    // -0 (window 1111) carries neg with zero magnitude, which yields 0
    sel_c.neg = win_i[3];
    unique case (win_i)
      4'b0001, 4'b0010, 4'b1101, 4'b1110: sel_c.one   = 1'b1;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: sel_c.two   = 1'b1;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: sel_c.three = 1'b1;
      4'b0111, 4'b1000:                   sel_c.four  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/r8mbe_seq_mult.sv
// Iterative radix-8 Modified Booth multiplier, one digit per cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (tc, a_in, b_in sampled together)
//   tc                  : 1 = two's-complement, 0 = unsigned
//   out_valid/out_ready : product handshake
//   product             : exact 2N-bit A*B, held until accepted
module r8mbe_seq_mult
  import r8mbe_pkg::*;
#(
  parameter int unsigned N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           tc,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int unsigned D    = r8_digits(N);
  localparam int unsigned AW   = N + 3;
  localparam int unsigned BW   = 3 * D;
  localparam int unsigned ACCW = 2 * N + 4;
  localparam int unsigned PW   = 2 * N;
  localparam int unsigned CW   = $clog2(D + 1);
  localparam int unsigned SW   = $clog2(3 * D);

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   a_q, a_d;
  logic        [BW-1:0]   b_q, b_d;
  logic                   bm1_q, bm1_d;
  logic signed [AW-1:0]   m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, m4_q, m4_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic        [CW-1:0]   cnt_q, cnt_d;
  logic        [PW-1:0]   product_q, product_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;

  digit_sel_t             sel_c;
  logic signed [AW-1:0]   mag_c, pp_c;
  logic signed [ACCW-1:0] pp_ext_c;
  logic        [SW-1:0]   sh_c;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

  // B is consumed three bits per cycle; bm1_q holds the overlap bit b[3i-1]
  r8mbe_digit_enc u_enc (
    .win_i ({b_q[2:0], bm1_q}),
    .sel_c (sel_c)
  );

  // Partial product d_i*A from the precomputed multiples, placed at weight 8^i
  always_comb begin
    mag_c = '0;
    if (sel_c.one)   mag_c = m1_q;
    if (sel_c.two)   mag_c = m2_q;
    if (sel_c.three) mag_c = m3_q;
    if (sel_c.four)  mag_c = m4_q;
    pp_c     = sel_c.neg ? -mag_c : mag_c;
    pp_ext_c = ACCW'(pp_c);
    sh_c     = SW'(cnt_q) * SW'(3);
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    bm1_d       = bm1_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    m3_d        = m3_q;
    m4_d        = m4_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = {{3{tc & a_in[N-1]}}, a_in};
          b_d     = {{(BW-N){tc & b_in[N-1]}}, b_in};
          bm1_d   = 1'b0;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        m1_d    = a_q;
        m2_d    = a_q <<< 1;
        m3_d    = a_q + (a_q <<< 1);
        m4_d    = a_q <<< 2;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        // cnt_q == D is the writeback cycle after the last digit has landed
        if (cnt_q == CW'(D)) begin
          product_d = acc_q[PW-1:0];
          state_d   = ST_DONE;
        end else begin
          acc_d = acc_q + (pp_ext_c <<< sh_c);
          b_d   = b_q >> 3;
          bm1_d = b_q[2];
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      bm1_q       <= 1'b0;
      m1_q        <= '0;
      m2_q        <= '0;
      m3_q        <= '0;
      m4_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      bm1_q       <= bm1_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      m3_q        <= m3_d;
      m4_q        <= m4_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_r8mbe_seq_mult.sv
// Directed and randomised checks of the N=24 radix-8 Booth multiplier.
module tb_r8mbe_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        tc;
  logic [23:0] a_in;
  logic [23:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  r8mbe_seq_mult #(.N(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tc        (tc),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation with out_ready=1; check latency, product and handshake completion
  task automatic run_op(input string tag, input logic t, input logic [23:0] a,
                        input logic [23:0] b, input logic [47:0] exp);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tc = t; a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check({tag, "_lat"}, 64'(lat), 64'd11);
    check({tag, "_prod"}, 64'(product), 64'(exp));
    @(posedge clk);
    #1;
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ir_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [23:0] ra, rb;
    logic [47:0] held;
    longint      sa, sb;

    rst = 1'b1; in_valid = 1'b0; tc = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    run_op("u_1x2",     1'b0, 24'd1,       24'd2,       48'h000000000002);
    run_op("u_ones",    1'b0, 24'hFFFFFF,  24'hFFFFFF,  48'hFFFFFE000001);
    run_op("s_m3x5",    1'b1, 24'hFFFFFD,  24'h000005,  48'hFFFFFFFFFFF1);
    run_op("s_minmin",  1'b1, 24'h800000,  24'h800000,  48'h400000000000);
    run_op("u_7x3",     1'b0, 24'd7,       24'd3,       48'h000000000015);
    run_op("u_minmin",  1'b0, 24'h800000,  24'h800000,  48'h400000000000);
    run_op("s_m1xm1",   1'b1, 24'hFFFFFF,  24'hFFFFFF,  48'h000000000001);
    run_op("s_maxmin",  1'b1, 24'h7FFFFF,  24'h800000,  48'hC00000800000);
    run_op("u_zero",    1'b0, 24'h000000,  24'h123456,  48'h000000000000);
    run_op("s_4xmin",   1'b1, 24'h800000,  24'h000004,  48'hFFFFFE000000);

    // Randomised pairs against a reference multiply
    for (int i = 0; i < 1000; i++) begin
      ra = 24'($urandom); rb = 24'($urandom);
      run_op("rand_u", 1'b0, ra, rb, {24'd0, ra} * {24'd0, rb});
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 24'($urandom); rb = 24'($urandom);
      sa = longint'($signed(ra)); sb = longint'($signed(rb));
      run_op("rand_s", 1'b1, ra, rb, 48'(sa * sb));
    end

    // Backpressure: hold result while out_ready=0, in_valid pulses ignored
    @(negedge clk);
    tc = 1'b0; a_in = 24'd1000; b_in = 24'd1000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 40 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_prod", 64'(product), 64'd1000000);
    held = product;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0]; a_in = 24'd5; b_in = 24'd5;
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_prod", 64'(product), 64'(held));
      check("bp_hold_ir", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ir", 64'(in_ready), 64'd1);
    check("bp_release_prod", 64'(product), 64'd1000000);

    // Reset mid-accumulation (digit 4) discards the operation
    @(negedge clk);
    tc = 1'b1; a_in = 24'h123456; b_in = 24'h654321; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_product", 64'(product), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_7x3", 1'b0, 24'd7, 24'd3, 48'h000000000015);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
